// File: rtl/jericalla_pkg.sv
// rtl/jericalla_pkg.sv - shared opcodes, FSM encoding and instruction field offsets
package jericalla_pkg;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_SLT = 4'b0100;
   localparam logic [3:0] OP_LW  = 4'b0101;
   localparam logic [3:0] OP_SW  = 4'b0110;
   localparam logic [3:0] OP_AND = 4'b0111;
   localparam logic [3:0] OP_OR  = 4'b1000;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   // Instruction layout is {op, rd, rs, rt}, MSB first.
   localparam int RT_LSB = 0;

   function automatic int rs_lsb(input int reg_aw);
      return reg_aw;
   endfunction

   function automatic int rd_lsb(input int reg_aw);
      return 2 * reg_aw;
   endfunction

   function automatic int op_lsb(input int reg_aw);
      return 3 * reg_aw;
   endfunction

endpackage

// File: rtl/jericalla_multiciclo_if.sv
// rtl/jericalla_multiciclo_if.sv - instruction handshake and observation bus
interface jericalla_multiciclo_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int OP_W   = 4
);
   localparam int INSTR_W = OP_W + 3 * REG_AW;

   logic [INSTR_W-1:0] instruction;
   logic               instr_valid;
   logic               instr_ready;
   logic [DATA_W-1:0]  data_out;
   logic               zf;
   logic               done;
   logic               err;

   modport master (
      output instruction, instr_valid,
      input  instr_ready, data_out, zf, done, err
   );

   modport slave (
      input  instruction, instr_valid,
      output instr_ready, data_out, zf, done, err
   );
endinterface

// File: rtl/banco_de_registros_param.sv
// rtl/banco_de_registros_param.sv - register bank, two async read ports, one sync write port
module banco_de_registros_param #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);
   // Contents are never reset; R0 is an ordinary register.
   logic [DATA_W-1:0] mem [2**REG_AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/jericalla_multiciclo.sv
// rtl/jericalla_multiciclo.sv - multi-cycle decode/exec/mem/wb datapath with handshake
module jericalla_multiciclo
   import jericalla_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int RAM_AW = 5,
   parameter int OP_W   = 4
) (
   input logic               clk,
   input logic               reset,
   jericalla_multiciclo_if.slave bus
);
   localparam int INSTR_W = OP_W + 3 * REG_AW;
   localparam int RS_LSB  = rs_lsb(REG_AW);
   localparam int RD_LSB  = rd_lsb(REG_AW);
   localparam int OP_LSB  = op_lsb(REG_AW);

   state_t             state;
   logic [INSTR_W-1:0] instr_q;
   logic [DATA_W-1:0]  a_q, b_q, res_q, data_out_q;
   logic [RAM_AW-1:0]  addr_q;
   logic               zf_q, done_q, err_q, ready_q;

   logic [DATA_W-1:0]  ram [2**RAM_AW];
   logic [OP_W-1:0]    op, op_in;
   logic [REG_AW-1:0]  rd, rs, rt;
   logic [DATA_W-1:0]  rdata_s, rdata_t, alu;
   logic               bank_we, ram_we, is_mem_op, is_sw;

   function automatic logic is_legal(input logic [OP_W-1:0] o);
      case (o)
         OP_W'(OP_NOP), OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_SLT),
         OP_W'(OP_LW),  OP_W'(OP_SW),  OP_W'(OP_AND), OP_W'(OP_OR): return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   assign op        = instr_q[OP_LSB +: OP_W];
   assign rd        = instr_q[RD_LSB +: REG_AW];
   assign rs        = instr_q[RS_LSB +: REG_AW];
   assign rt        = instr_q[RT_LSB +: REG_AW];
   assign op_in     = bus.instruction[OP_LSB +: OP_W];
   assign is_sw     = (op == OP_W'(OP_SW));
   assign is_mem_op = is_sw || (op == OP_W'(OP_LW));

   // Write enables derive from the async-reset state, so a reset aborts any pending write.
   assign bank_we = (state == S_WB);
   assign ram_we  = (state == S_MEM) && is_sw;

   banco_de_registros_param #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_bank (
      .clk     (clk),
      .we      (bank_we),
      .waddr   (rd),
      .wdata   (res_q),
      .raddr_a (rs),
      .raddr_b (rt),
      .rdata_a (rdata_s),
      .rdata_b (rdata_t)
   );

   always_comb begin
      alu = '0;
      case (op)
         OP_W'(OP_ADD): alu = a_q + b_q;
         OP_W'(OP_SUB): alu = a_q - b_q;
         OP_W'(OP_SLT): alu = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
         OP_W'(OP_AND): alu = a_q & b_q;
         OP_W'(OP_OR):  alu = a_q | b_q;
         default:       alu = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[addr_q] <= a_q;
      end
   end

   // done is raised on the edge entering the final state so it is high during that state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         instr_q    <= '0;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         addr_q     <= '0;
         data_out_q <= '0;
         zf_q       <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.instr_valid && ready_q) begin
                  instr_q <= bus.instruction;
                  ready_q <= 1'b0;
                  done_q  <= (op_in == OP_W'(OP_NOP)) || !is_legal(op_in);
                  err_q   <= !is_legal(op_in);
                  state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_q <= rdata_s;
               b_q <= rdata_t;
               if (done_q) begin
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  ready_q <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_mem_op) begin
                  addr_q <= b_q[RAM_AW-1:0];
                  done_q <= is_sw;
                  state  <= S_MEM;
               end else begin
                  res_q  <= alu;
                  zf_q   <= (alu == '0);
                  done_q <= 1'b1;
                  state  <= S_WB;
               end
            end
            S_MEM: begin
               if (is_sw) begin
                  data_out_q <= a_q;
                  done_q     <= 1'b0;
                  ready_q    <= 1'b1;
                  state      <= S_IDLE;
               end else begin
                  res_q  <= ram[addr_q];
                  done_q <= 1'b1;
                  state  <= S_WB;
               end
            end
            S_WB: begin
               data_out_q <= res_q;
               done_q     <= 1'b0;
               ready_q    <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.instr_ready = ready_q;
   assign bus.data_out    = data_out_q;
   assign bus.zf          = zf_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;
endmodule

// File: doc/jericalla_multiciclo.md
# jericalla_multiciclo

Parametrised multi-cycle successor of the Jericalla datapath. It accepts one instruction at a time over a valid/ready handshake and sequences it through a decode/execute/memory/write-back FSM. The FSM drives a parametrised register bank, ALU and data RAM. It sits between an instruction source (bench or future fetch unit) and the observation outputs `data_out`/`zf`. It adds LW, AND/OR, completion/error flags and back-pressure.

## Interface
- `DATA_W`, 32: register/RAM/ALU data width.
- `REG_AW`, 5: register address width; bank has 2^REG_AW entries.
- `RAM_AW`, 5: data RAM address width; RAM has 2^RAM_AW words.
- `OP_W`, 4: opcode width; `INSTR_W = OP_W + 3*REG_AW` (19 at defaults).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `instruction`  in  INSTR_W  fields `{op, rd, rs, rt}`, MSB first.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  block can accept (high only in IDLE).
- `data_out`  out  DATA_W  last result: ALU result, loaded word, or stored word.
- `zf`  out  1  last ALU result was zero.
- `done`  out  1  one-cycle pulse, instruction retired.
- `err`  out  1  one-cycle pulse with `done` for an illegal opcode.

## Operation
- Opcodes:
  - NOP 0000: no effect.
  - ADD 0010: R[rd] = R[rs] + R[rt].
  - SUB 0011: R[rd] = R[rs] − R[rt].
  - SLT 0100: R[rd] = (R[rs] < R[rt]) ? 1 : 0.
  - LW 0101: R[rd] = RAM[R[rt][RAM_AW-1:0]].
  - SW 0110: RAM[R[rt][RAM_AW-1:0]] = R[rs]; `rd` is ignored.
  - AND 0111, OR 1000: bitwise.
  - Any other opcode is illegal.
- Arithmetic is unsigned, wraps modulo 2^DATA_W, and has no carry/overflow output. SLT compares unsigned.
- RAM addressing uses only the low RAM_AW bits of R[rt]; upper bits are ignored (wrap-around).
- All registers, including R0, are writable. There is no reset of bank or RAM contents. The bank array is named `mem` so the bench can preload it with `$readmemb`.
- FSM states: IDLE, DECODE, EXEC, MEM, WB.
  - IDLE: a handshake `instr_valid & instr_ready` latches `instruction`, then → DECODE.
  - DECODE: reads R[rs] and R[rt] into operand registers. Illegal opcode → IDLE with `done=1` and `err=1`. NOP → IDLE with `done=1`. Otherwise → EXEC.
  - EXEC: ALU ops latch the result and update `zf`, then → WB. LW/SW latch the address, then → MEM.
  - MEM:
    - SW: RAM write, `data_out` ← stored word, `done=1`, → IDLE.
    - LW: synchronous RAM read, → WB.
  - WB: bank write of R[rd], `data_out` ← result, `done=1`, → IDLE.
- `zf` changes only on ALU ops. LW, SW and NOP leave it unchanged.
- `instruction` changes while not in IDLE are ignored.

## Timing
- Reset (async assert, sync release) values:
  - FSM = IDLE
  - `instr_ready` = 1
  - `data_out` = 0
  - `zf` = 0
  - `done` = 0
  - `err` = 0
- Reset mid-instruction aborts it. A pending bank or RAM write in that cycle does not occur.
- Latency from the accept edge (cycle 0) to the `done` cycle:
  - ALU ops: cycle 3
  - LW: cycle 4
  - SW: cycle 3
  - NOP/illegal: cycle 1
- `done` is registered and asserted in the final state. `data_out`, `zf` and the bank/RAM contents are valid from the cycle after `done`.
- `instr_ready` is high again the cycle after `done`. Back-to-back issue therefore gives one instruction per latency+1 cycles.
- `rd == rs` or `rd == rt` is safe, because operands are captured in DECODE.
- LW directly following a SW to the same address returns the new value.

## Structure
- Shared package `jericalla_pkg` holds:
  - the opcode localparams
  - the FSM state enum/encoding
  - the field-slice helper constants (op/rd/rs/rt offsets derived from REG_AW)
- Sub-module `banco_de_registros_param` (parametrised by DATA_W, REG_AW):
  - two combinational read ports, one synchronous write port
  - array `mem`
- ALU and RAM are inline.

## Test plan
- Preload R0=222, R1=111, R2=100, R3=200. ADD rd=4, rs=0, rt=1 → `done` at cycle 3, R4=333, `data_out`=333, `zf`=0.
- SUB rd=5, rs=1, rt=2 → R5=11. SUB rd=6, rs=1, rt=1 → R6=0, `zf`=1. SLT rd=7, rs=2, rt=3 → R7=1.
- Set R8=20. SW rs=4, rt=8 → RAM[20]=333, `done` at cycle 3. LW rd=9, rt=8 → R9=333 at cycle 4, `zf` unchanged. With R10=52, LW rt=10 reads RAM[20] (wrap at RAM_AW=5).
- Opcode 1111 → `done` and `err` pulse at cycle 1, no register/RAM change. `instr_valid` held high continuously → each new accept occurs only when `instr_ready`=1.
- Assert `reset` low during EXEC of ADD rd=11 → outputs return to reset values, R11 unchanged, `instr_ready`=1 after release.
- Re-elaborate with DATA_W=8: ADD of 200+100 → 44 (wrap), `zf`=0. 128+128 → 0, `zf`=1.
